// File: rtl/alu_pkg.sv
// Shared ALU opcodes, MUL/DIV sequencer state type and width helpers.
// Imported by the ALU control decoder and the execution stage.
package alu_pkg;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0011;
   localparam logic [3:0] ALU_XOR = 4'b0100;
   localparam logic [3:0] ALU_SLL = 4'b0101;
   localparam logic [3:0] ALU_SRL = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_MUL = 4'b1000;
   localparam logic [3:0] ALU_DIV = 4'b1001;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2
   } seqState_t;

   function automatic int shamtWidth(input int width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative shift-add MUL / restoring DIV, one bit per cycle over WIDTH cycles.
// busy is high for WIDTH cycles after go; fin marks the last iteration with lo/hi final.
module alu_muldiv_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             go,
   input  logic             is_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             fin,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi
);

   localparam int CW = $clog2(WIDTH) + 1;

   seqState_t        state, stateNxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] hiReg, loReg, divisor;
   logic [WIDTH-1:0] hiNxt, loNxt;
   logic [WIDTH:0]   addSum, trial;

   always_comb begin
      stateNxt = state;
      hiNxt    = hiReg;
      loNxt    = loReg;
      addSum   = '0;
      trial    = '0;
      case (state)
         IDLE: begin
            if (go) stateNxt = is_div ? DIV : MUL;
         end
         MUL: begin
            // hi accumulates partial products; the multiplier drains out of lo
            addSum         = {1'b0, hiReg} + (loReg[0] ? {1'b0, divisor} : '0);
            {hiNxt, loNxt} = {addSum, loReg[WIDTH-1:1]};
            if (cnt == CW'(1)) stateNxt = IDLE;
         end
         DIV: begin
            // hi is the partial remainder; trial[WIDTH] set means the subtract borrowed
            trial = {hiReg, loReg[WIDTH-1]} - {1'b0, divisor};
            hiNxt = trial[WIDTH] ? {hiReg[WIDTH-2:0], loReg[WIDTH-1]} : trial[WIDTH-1:0];
            loNxt = {loReg[WIDTH-2:0], ~trial[WIDTH]};
            if (cnt == CW'(1)) stateNxt = IDLE;
         end
         default: stateNxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         hiReg   <= '0;
         loReg   <= '0;
         divisor <= '0;
      end else begin
         state <= stateNxt;
         if (state == IDLE) begin
            if (go) begin
               cnt     <= CW'(WIDTH);
               hiReg   <= '0;
               loReg   <= a;
               divisor <= b;
            end
         end else begin
            cnt   <= cnt - CW'(1);
            hiReg <= hiNxt;
            loReg <= loNxt;
         end
      end
   end

   assign busy = (state != IDLE);
   assign fin  = (state != IDLE) && (cnt == CW'(1));
   assign lo   = loNxt;
   assign hi   = hiNxt;

endmodule

// File: rtl/alu_exec.sv
// Execution-stage ALU: single-cycle ops done next cycle, MUL/DIV done WIDTH+1 cycles after issue.
// start is ignored while busy; the pipeline stalls on busy, no queueing.
module alu_exec
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       alu_cnt,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             zero,
   output logic             div_by_zero,
   output logic             illegal_op
);

   localparam int SHW = shamtWidth(WIDTH);

   logic             accept, seqGo, seqBusy, seqFin;
   logic [WIDTH-1:0] seqLo, seqHi;
   logic [WIDTH-1:0] quickRes, quickHi;
   logic             quickDbz, quickIll;
   logic [SHW-1:0]   shamt;

   assign shamt  = src_b[SHW-1:0];
   assign accept = start && !seqBusy;
   assign busy   = seqBusy;

   always_comb begin
      quickRes = '0;
      quickHi  = '0;
      quickDbz = 1'b0;
      quickIll = 1'b0;
      seqGo    = 1'b0;
      case (alu_cnt)
         ALU_ADD: quickRes = src_a + src_b;
         ALU_SUB: quickRes = src_a - src_b;
         ALU_AND: quickRes = src_a & src_b;
         ALU_OR:  quickRes = src_a | src_b;
         ALU_XOR: quickRes = src_a ^ src_b;
         ALU_SLL: quickRes = src_a << shamt;
         ALU_SRL: quickRes = src_a >> shamt;
         ALU_SLT: quickRes = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
         ALU_MUL: seqGo = accept;
         ALU_DIV: begin
            // divide by zero never enters the sequencer
            if (src_b == '0) begin
               quickRes = '1;
               quickHi  = src_a;
               quickDbz = 1'b1;
            end else begin
               seqGo = accept;
            end
         end
         default: quickIll = 1'b1;
      endcase
   end

   alu_muldiv_seq #(.WIDTH(WIDTH)) uSeq (
      .clk    (clk),
      .rst    (rst),
      .go     (seqGo),
      .is_div (alu_cnt == ALU_DIV),
      .a      (src_a),
      .b      (src_b),
      .busy   (seqBusy),
      .fin    (seqFin),
      .lo     (seqLo),
      .hi     (seqHi)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         done        <= 1'b0;
         result      <= '0;
         result_hi   <= '0;
         zero        <= 1'b0;
         div_by_zero <= 1'b0;
         illegal_op  <= 1'b0;
      end else begin
         done <= 1'b0;
         // seqFin and accept are exclusive: accept needs busy low, seqFin needs it high
         if (seqFin) begin
            done        <= 1'b1;
            result      <= seqLo;
            result_hi   <= seqHi;
            zero        <= (seqLo == '0);
            div_by_zero <= 1'b0;
            illegal_op  <= 1'b0;
         end else if (accept && !seqGo) begin
            done        <= 1'b1;
            result      <= quickRes;
            result_hi   <= quickHi;
            zero        <= (quickRes == '0);
            div_by_zero <= quickDbz;
            illegal_op  <= quickIll;
         end
      end
   end

endmodule

// File: doc/alu_exec.md
# alu_exec

Execution-stage ALU that consumes the 4-bit `alu_cnt` code from the ALU control decoder plus two register operands and produces a registered result. Logic, arithmetic, shift and compare operations complete in one cycle. MUL and DIV run iteratively over `WIDTH` cycles, with a start/busy/done handshake that the pipeline controller uses to stall.

## Interface

- `WIDTH`, default 16: operand and result width; must be a power of 2, at least 4.
- `clk` in 1: the only clock. All state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: issues an operation. Sampled only when `busy`=0.
- `alu_cnt` in 4: operation code from the ALU control decoder.
- `src_a` in WIDTH: operand A.
- `src_b` in WIDTH: operand B.
- `busy` out 1: a MUL/DIV is in progress.
- `done` out 1: one-cycle pulse; result outputs are valid from this cycle.
- `result` out WIDTH: primary result. Also the MUL low half and the DIV quotient.
- `result_hi` out WIDTH: MUL high half or DIV remainder. 0 for all other ops.
- `zero` out 1: `result` == 0.
- `div_by_zero` out 1: the last DIV had `src_b`=0.
- `illegal_op` out 1: the last `alu_cnt` was undefined.

## Operation

- Opcodes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR: all modulo 2^WIDTH.
  - 0101 SLL, 0110 SRL: logical shifts; the amount is `src_b[log2(WIDTH)-1:0]`.
  - 0111 SLT: signed two's-complement compare; result is 1 or 0.
  - 1000 MUL: unsigned, 2·WIDTH-bit product.
  - 1001 DIV: unsigned quotient and remainder.
  - 1010–1111: illegal.
- Operands and opcode are captured on the edge where `start`=1 and `busy`=0. Later input changes have no effect on the issued op.
- Single-cycle ops:
  - `result`, `zero` and `done` register on that same edge.
  - `result_hi`=0, `div_by_zero`=0, `illegal_op`=0.
- Illegal op:
  - Completes in single-cycle timing with `result`=0, `result_hi`=0, `zero`=1, `illegal_op`=1.
- MUL uses shift-add, one multiplier bit per cycle, for WIDTH iterations.
- DIV uses restoring division, one quotient bit per cycle, for WIDTH iterations.
- Divide by zero takes no iterations and completes in single-cycle timing:
  - `result` = all ones.
  - `result_hi` = `src_a`.
  - `div_by_zero`=1.
- FSM states: IDLE, MUL, DIV.
  - IDLE→MUL on start with a MUL opcode.
  - IDLE→DIV on start with a DIV opcode and `src_b`≠0.
  - MUL/DIV→IDLE when the iteration counter reaches 0.
- `start` while `busy`=1 is ignored. No queueing, no error flag.
- All outputs except `done` hold their values until the next completion.
- `rst` (including mid-operation):
  - State → IDLE; counter and all outputs → 0.
  - No `done` is produced for the aborted op.

## Timing

- Reset values: `busy`=0, `done`=0, `result`=0, `result_hi`=0, `zero`=0, `div_by_zero`=0, `illegal_op`=0.
- Single-cycle op, illegal op, or divide by zero issued in cycle t:
  - `done`=1 and outputs valid in t+1.
  - `busy` stays 0.
- MUL/DIV issued in cycle t:
  - `busy`=1 in cycles t+1 through t+WIDTH.
  - `done`=1 with final outputs in t+WIDTH+1, where `busy`=0.
- A new `start` is accepted in any cycle where `busy`=0, including the cycle in which `done`=1. This allows back-to-back issue.
- `done` is never high for 2 consecutive cycles from a single op.
- `rst` and `start` in the same cycle: `rst` wins.

## Structure

- Package `alu_pkg` holds:
  - the opcode localparams (`ALU_ADD` … `ALU_DIV`);
  - the FSM state typedef (IDLE/MUL/DIV);
  - a WIDTH-derived shift-amount-width function.
- The ALU control decoder imports the same opcode constants.
- Sub-module `alu_muldiv_seq` contains the iterative MUL/DIV datapath, the counter and its FSM. Its interface is `go`, `is_div`, the operands, `busy`, `fin`, `lo` and `hi`.
- `alu_exec` contains the single-cycle datapath, the output registers and the handshake muxing.

## Test plan

1. ADD 0x7FFF + 0x0001 (WIDTH=16) → `result`=0x8000, `zero`=0, `done` at t+1, `busy` never high. SUB 0x0005 − 0x0005 → `result`=0, `zero`=1.
2. SLT `src_a`=0xFFFF, `src_b`=0x0001 → `result`=1. SRL 0x8000 by `src_b`=0x0013 (amount 3) → `result`=0x1000.
3. MUL 0x1234 × 0x0100 → `busy` high t+1..t+16; `done` at t+17 with `result`=0x3400, `result_hi`=0x0012. A `start` pulse with an ADD opcode at t+5 is ignored.
4. DIV 100 / 7 → `done` at t+17, `result`=14, `result_hi`=2. DIV 0x00AB / 0 → `done` at t+1, `result`=0xFFFF, `result_hi`=0x00AB, `div_by_zero`=1.
5. MUL issued, `rst` asserted at t+5 → next cycle `busy`=0 and all outputs 0. No `done` appears within 20 cycles, and a fresh ADD issued afterwards completes normally.
6. `alu_cnt`=1111 → `done` at t+1, `illegal_op`=1, `result`=0. A following valid op clears `illegal_op`. A MUL issued in the same cycle as a prior `done` is accepted (back-to-back).
